// File: rtl/proc_memory_if.sv
// Processor fetch/data ports plus the byte-stream loader handshake for proc_memory.
// LD_CSUM_EN adds the 8-bit loader checksum signal.
interface proc_memory_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
);
  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] inst;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] mem_out;
  logic             we;
  logic             ld_start;
  logic             ld_valid;
  logic [7:0]       ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             ld_done;
  logic             ld_ovf;
  logic             cpu_rst;
`ifdef LD_CSUM_EN
  logic [7:0]       ld_csum;
`endif

  modport master (
    output pc, mem_addr, mem_out, we, ld_start, ld_valid, ld_data, ld_last,
    input  inst, mem_in, ld_ready, ld_done, ld_ovf, cpu_rst
`ifdef LD_CSUM_EN
    , input ld_csum
`endif
  );

  modport slave (
    input  pc, mem_addr, mem_out, we, ld_start, ld_valid, ld_data, ld_last,
    output inst, mem_in, ld_ready, ld_done, ld_ovf, cpu_rst
`ifdef LD_CSUM_EN
    , output ld_csum
`endif
  );
endinterface

// File: rtl/proc_memory.sv
// Unified instruction/data memory with a byte-stream image loader that holds the CPU in reset.
// Reads are combinational in RUN; LD_CSUM_EN adds a modulo-256 checksum of loaded bytes.
module proc_memory #(
  parameter int WIDTH = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 65536
) (
  input logic         clk,
  input logic         rst,
  proc_memory_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] asm_q;
  logic             ld_ready_q;
  logic             ld_done_q;
  logic             ld_ovf_q;
  logic             cpu_rst_q;

  logic             ld_acc;
  logic             word_end;
  logic             ld_wr;
  logic             cpu_wr;
  logic             ptr_wrap;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] ld_word;
  logic [PW-1:0]    pc_idx;
  logic [PW-1:0]    da_idx;

  function automatic logic [PW-1:0] to_idx(input logic [AW-1:0] a);
    return PW'(32'(a) % DEPTH);
  endfunction

  assign pc_idx   = to_idx(bus.pc);
  assign da_idx   = to_idx(bus.mem_addr);
  assign ld_acc   = ld_ready_q & bus.ld_valid;
  assign word_end = (cnt == CW'(NB - 1));
  assign ld_wr    = ld_acc & (word_end | bus.ld_last);
  assign cpu_wr   = (state == RUN) & bus.we;
  assign ptr_wrap = (ptr == PW'(DEPTH - 1));

  // Bytes are kept right-aligned while assembling; a short final word is
  // shifted up so the unfilled low bytes come out as zero.
  assign merged  = (asm_q << 8) | WIDTH'(bus.ld_data);
  assign ld_word = merged << (8 * (CW'(NB - 1) - cnt));

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[ptr] <= ld_word;
    end else if (cpu_wr) begin
      mem[da_idx] <= bus.mem_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      asm_q      <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_ovf_q   <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.ld_start) begin
            state      <= LOAD;
            ptr        <= '0;
            cnt        <= '0;
            asm_q      <= '0;
            ld_ovf_q   <= 1'b0;
            ld_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_acc) begin
            if (ld_wr) begin
              cnt   <= '0;
              asm_q <= '0;
              ptr   <= ptr_wrap ? '0 : ptr + 1'b1;
              if (ptr_wrap) ld_ovf_q <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              asm_q <= merged;
            end
            if (bus.ld_last) begin
              state      <= RUN;
              ld_ready_q <= 1'b0;
              cpu_rst_q  <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          ld_ready_q <= 1'b0;
          cpu_rst_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef LD_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if ((state != LOAD) && bus.ld_start) begin
      csum_q <= '0;
    end else if (ld_acc) begin
      csum_q <= csum_q + bus.ld_data;
    end
  end

  assign bus.ld_csum = csum_q;
`endif

  assign bus.inst     = (state == RUN) ? mem[pc_idx] : '0;
  assign bus.mem_in   = (state == RUN) ? mem[da_idx] : '0;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_ovf   = ld_ovf_q;
  assign bus.cpu_rst  = cpu_rst_q;
endmodule

// File: tb/tb_proc_memory.sv
// Randomized bench for proc_memory: image loads, RUN reads/writes and resets against a word-array model.
module tb_proc_memory;
  localparam int WIDTH = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int NB    = WIDTH / 8;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_memory_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  proc_memory #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               known   [DEPTH];
  bit               ref_ovf;
  logic [7:0]       ref_csum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] alias_of(input int a);
    int k;
    k = $urandom_range(0, (1 << AW) / DEPTH - 1);
    return AW'(a + DEPTH * k);
  endfunction

  // Image bytes fill consecutive words from address 0, MSB first, modulo DEPTH.
  task automatic model_image(input bq_t img);
    int nw;
    logic [WIDTH-1:0] v;
    nw = (img.size() + NB - 1) / NB;
    ref_csum = 8'h00;
    foreach (img[i]) ref_csum = ref_csum + img[i];
    for (int w = 0; w < nw; w++) begin
      v = '0;
      for (int b = 0; b < NB; b++) begin
        v = v << 8;
        if (w * NB + b < img.size()) v = v | WIDTH'(img[w * NB + b]);
      end
      ref_mem[w % DEPTH] = v;
      known[w % DEPTH]   = 1'b1;
    end
    ref_ovf = (nw >= DEPTH);
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check("ld_ready_entry", bus.ld_ready, 1);
    check("cpu_rst_load", bus.cpu_rst, 1);
  endtask

  task automatic send_bytes(input bq_t img, input bit finish, input bit noise);
    for (int i = 0; i < img.size(); i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'($urandom);
        bus.ld_last  = 1'($urandom);
        if (noise) begin
          bus.we       = 1'b1;
          bus.mem_addr = alias_of($urandom_range(0, DEPTH - 1));
          bus.mem_out  = WIDTH'($urandom);
          bus.pc       = bus.mem_addr;
          bus.ld_start = 1'($urandom);
          #1;
          check("inst_zero_load", bus.inst, 0);
          check("mem_in_zero_load", bus.mem_in, 0);
        end
        tick();
      end
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_data  = img[i];
      bus.ld_last  = finish && (i == img.size() - 1);
      tick();
      bus.we = 1'b0;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.we       = 1'b0;
    bus.ld_start = 1'b0;
  endtask

  task automatic load_image(input bq_t img, input bit noise);
    start_load();
    send_bytes(img, 1'b1, noise);
    model_image(img);
    check("ld_done_pulse", bus.ld_done, 1);
    check("cpu_rst_run", bus.cpu_rst, 0);
    check("ld_ready_run", bus.ld_ready, 0);
    check("ld_ovf", bus.ld_ovf, ref_ovf);
`ifdef LD_CSUM_EN
    check("ld_csum", bus.ld_csum, ref_csum);
`endif
    tick();
    check("ld_done_low", bus.ld_done, 0);
  endtask

  task automatic verify_all();
    for (int a = 0; a < DEPTH; a++) begin
      if (known[a]) begin
        int b;
        b = $urandom_range(0, DEPTH - 1);
        if (!known[b]) b = a;
        bus.pc       = alias_of(a);
        bus.mem_addr = alias_of(b);
        #1;
        check($sformatf("inst[%0d]", a), bus.inst, ref_mem[a]);
        check($sformatf("mem_in[%0d]", b), bus.mem_in, ref_mem[b]);
      end
    end
  endtask

  task automatic run_write(input int a, input logic [WIDTH-1:0] d);
    bus.we       = 1'b1;
    bus.mem_addr = alias_of(a);
    bus.pc       = alias_of(a);
    bus.mem_out  = d;
    bus.ld_valid = 1'($urandom);
    bus.ld_data  = 8'($urandom);
    #1;
    if (known[a]) check("mem_in_old", bus.mem_in, ref_mem[a]);
    tick();
    bus.we       = 1'b0;
    bus.ld_valid = 1'b0;
    ref_mem[a] = d;
    known[a]   = 1'b1;
    #1;
    check("mem_in_new", bus.mem_in, d);
    check("inst_new", bus.inst, d);
  endtask

  bq_t img;

  initial begin
    rst = 1'b1;
    bus.pc = '0; bus.mem_addr = '0; bus.mem_out = '0; bus.we = 1'b0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
    repeat (2) tick();
    check("rst_cpu_rst", bus.cpu_rst, 1);
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_ld_done", bus.ld_done, 0);
    check("rst_ld_ovf", bus.ld_ovf, 0);
    check("rst_inst", bus.inst, 0);
    rst = 1'b0;

    // IDLE drops loader bytes
    bus.ld_valid = 1'b1; bus.ld_data = 8'h5A; bus.ld_last = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    check("idle_ld_ready", bus.ld_ready, 0);
    check("idle_cpu_rst", bus.cpu_rst, 1);

    img = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    load_image(img, 1'b0);
    verify_all();

    img = '{8'h01, 8'h02, 8'h03};
    load_image(img, 1'b0);
    verify_all();

    // Full image with processor writes and ld_start pulses during LOAD (both ignored)
    img = {};
    for (int i = 0; i < DEPTH * NB; i++) img.push_back(8'($urandom));
    load_image(img, 1'b1);
    verify_all();

    run_write(16'h0010 % DEPTH, 16'h5555);
    for (int i = 0; i < 30; i++) run_write($urandom_range(0, DEPTH - 1), WIDTH'($urandom));
    verify_all();

    // Wrap: DEPTH+1 words overwrite from address 0
    img = {};
    for (int w = 1; w <= DEPTH + 1; w++) begin
      img.push_back(8'(w >> 8));
      img.push_back(8'(w));
    end
    load_image(img, 1'b0);
    verify_all();

    for (int r = 0; r < 4; r++) begin
      img = {};
      for (int i = 0, n = $urandom_range(1, 2 * DEPTH * NB + 1); i < n; i++)
        img.push_back(8'($urandom));
      load_image(img, 1'b1);
      verify_all();
    end

    // Async reset mid-load: completed word kept, partial discarded
    start_load();
    img = '{8'hAA, 8'hBB, 8'hCC};
    send_bytes(img, 1'b0, 1'b0);
    ref_mem[0] = 16'hAABB;
    known[0]   = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_cpu_rst", bus.cpu_rst, 1);
    check("midrst_ld_ready", bus.ld_ready, 0);
    check("midrst_inst", bus.inst, 0);
    tick();
    rst = 1'b0;
    tick();
    img = '{8'h77};
    load_image(img, 1'b0);
    verify_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
